// File: rtl/decim_frame_pkg.sv
// Shared types for the decimator frame buffer: reader states, bank index, default geometry.
package decim_frame_pkg;

    localparam int FRAME_LEN_DFLT = 256;
    localparam int ADDR_W         = $clog2(FRAME_LEN_DFLT);

    typedef logic bank_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (BRAM style).
module frame_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 9
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_BITS-1:0]         waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic                         re,
    input  logic [ADDR_BITS-1:0]         raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/decim_frame_buffer.sv
// Ping-pong frame buffer: packs the non-stallable decimated stream into frames and
// replays each full bank as a ready/valid stream, dropping (and flagging) samples on overflow.
module decim_frame_buffer
    import decim_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_last,
    output logic                         overrun
);

    localparam int            AW        = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    logic [AW-1:0] wr_ptr;
    bank_t         wr_bank;
    logic [1:0]    full;
    logic [1:0]    full_n;
    logic          wr_en;
    logic          wr_wrap;

    rd_state_t     rd_state;
    bank_t         rd_bank;
    logic [AW-1:0] rd_addr;
    logic          rd_done;
    logic          rd_issue;

    logic                         rd_vld_p1;
    logic                         rd_last_p1;
    logic signed [DATA_WIDTH-1:0] rd_data_p1;
    logic                         skid_vld;
    logic                         skid_last;
    logic signed [DATA_WIDTH-1:0] skid_data;

    logic       pop;
    logic       head_last;
    logic       frame_done;
    logic       q_stays;
    logic [1:0] occ_after_pop;

    // A full target bank is sampled before any same-cycle release, so that sample is dropped.
    assign wr_en   = valid_in && !full[wr_bank];
    assign wr_wrap = wr_en && (wr_ptr == LAST_ADDR);

    assign m_valid    = skid_vld || rd_vld_p1;
    assign head_last  = skid_vld ? skid_last : rd_last_p1;
    assign m_data     = skid_vld ? skid_data : (rd_vld_p1 ? rd_data_p1 : '0);
    assign m_last     = m_valid && head_last;
    assign pop        = m_valid && m_ready;
    assign frame_done = pop && head_last;

    // The RAM output register is the head unless the skid holds an older sample.
    assign q_stays       = rd_vld_p1 && !(pop && !skid_vld);
    assign occ_after_pop = {1'b0, skid_vld} + {1'b0, rd_vld_p1} - {1'b0, pop};
    assign rd_issue      = ((rd_state == RD_PRIME) || ((rd_state == RD_STREAM) && !rd_done))
                           && (occ_after_pop <= 2'd1);

    always_comb begin
        full_n = full;
        if (wr_wrap) begin
            full_n[wr_bank] = 1'b1;
        end
        if (frame_done) begin
            full_n[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            full    <= '0;
            overrun <= 1'b0;
        end else begin
            full <= full_n;
            if (valid_in && full[wr_bank]) begin
                overrun <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (wr_wrap) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state   <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            rd_done    <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            skid_vld   <= 1'b0;
            skid_last  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= RD_PRIME;
                    end
                end
                RD_PRIME: begin
                    if (rd_issue) begin
                        rd_state <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (frame_done) begin
                        rd_state <= full_n[~rd_bank] ? RD_PRIME : RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase

            if (frame_done) begin
                rd_bank <= ~rd_bank;
                rd_done <= 1'b0;
            end
            if (rd_issue) begin
                rd_addr <= rd_addr + AW'(1);
                if (rd_addr == LAST_ADDR) begin
                    rd_done <= 1'b1;
                end
            end

            // Read-ahead: an unconsumed RAM output moves into the skid before being overwritten.
            if (rd_issue) begin
                rd_vld_p1  <= 1'b1;
                rd_last_p1 <= (rd_addr == LAST_ADDR);
                skid_vld   <= q_stays;
                if (q_stays) begin
                    skid_last <= rd_last_p1;
                end
            end else begin
                rd_vld_p1 <= q_stays;
                skid_vld  <= skid_vld && !pop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_issue && q_stays) begin
            skid_data <= rd_data_p1;
        end
    end

    frame_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (AW + 1)
    ) u_frame_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (data_in),
        .re    (rd_issue),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data_p1)
    );

endmodule

// File: tb/tb_decim_frame_buffer.sv
// Bench for decim_frame_buffer (FRAME_LEN = 8): frame-level reference model plus directed literal checks.
module tb_decim_frame_buffer;

    localparam int DW  = 16;
    localparam int FL  = 8;

    typedef logic signed [DW-1:0] s16_t;

    logic          clk;
    logic          rst;
    logic          valid_in;
    s16_t          data_in;
    logic          m_valid;
    logic          m_ready;
    s16_t          m_data;
    logic          m_last;
    logic          overrun;

    int vectors     = 0;
    int miscompares = 0;

    decim_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: completed frames awaiting output, the partial frame, sticky overrun.
    s16_t exp_q[$];
    bit   exp_last[$];
    s16_t part[$];
    int   pending   = 0;
    bit   m_ovr     = 0;
    s16_t got_q[$];
    int   hs_cyc[$];
    int   last_hs   = 0;
    int   ncyc      = 0;
    int   t_frame   = 0;
    int   t_rise    = 0;
    bit   rst_prev_low = 0;
    bit   prev_stall   = 0;
    bit   prev_hs_nl   = 0;
    bit   prev_valid   = 0;
    s16_t pd;
    bit   pl;
    int   gap_wait  = 0;
    int   rdy_mode  = 0;
    int   rdy_pct   = 50;

    task automatic fail_line(string name, int act, int req);
        miscompares++;
        $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic chk(string name, int act, int req);
        vectors++;
        if (act !== req) fail_line(name, act, req);
    endtask

    always @(negedge clk) begin
        bit drop;
        bit hs;
        bit hl;
        ncyc++;
        if (!rst) begin
            if (rst_prev_low) begin
                vectors++;
                if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || overrun !== 1'b0)
                    fail_line("reset_state", {m_valid, m_last, overrun}, 0);
            end
            rst_prev_low = 1;
            exp_q.delete(); exp_last.delete(); part.delete();
            pending = 0; m_ovr = 0;
            prev_stall = 0; prev_hs_nl = 0; prev_valid = 0; gap_wait = 0;
        end else begin
            rst_prev_low = 0;
            chk("overrun_track", overrun, m_ovr);
            if (prev_stall) begin
                vectors++;
                if (!(m_valid === 1'b1 && m_data === pd && m_last === pl))
                    fail_line("stall_hold", m_data, pd);
            end
            if (prev_hs_nl) chk("no_bubble", m_valid, 1);
            if (gap_wait > 0) begin
                if (m_valid === 1'b1) begin
                    vectors++;
                    gap_wait = 0;
                end else begin
                    gap_wait--;
                    if (gap_wait == 0) begin
                        vectors++;
                        fail_line("frame_gap", 0, 1);
                    end
                end
            end
            if (m_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) fail_line("spurious_valid", 1, 0);
            end
            if (m_valid === 1'b1 && !prev_valid) t_rise = ncyc;

            drop = valid_in && (part.size() == 0) && (pending == 2);
            hs   = m_valid && m_ready;
            prev_hs_nl = 0;
            if (hs) begin
                got_q.push_back(m_data);
                hs_cyc.push_back(ncyc);
                if (m_last) last_hs++;
                if (exp_q.size() > 0) begin
                    hl = exp_last[0];
                    chk("data", m_data, exp_q[0]);
                    chk("last", m_last, hl);
                    void'(exp_q.pop_front());
                    void'(exp_last.pop_front());
                    if (hl) begin
                        pending--;
                        if (exp_q.size() > 0) gap_wait = 3;
                    end else begin
                        prev_hs_nl = 1;
                    end
                end
            end
            if (valid_in) begin
                if (drop) begin
                    m_ovr = 1;
                end else begin
                    part.push_back(data_in);
                    if (part.size() == FL) begin
                        foreach (part[i]) begin
                            exp_q.push_back(part[i]);
                            exp_last.push_back(i == FL - 1);
                        end
                        part.delete();
                        pending++;
                        t_frame = ncyc;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            prev_valid = m_valid;
        end
    end

    initial begin
        int pat = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                2: begin m_ready = (pat % 3 == 0); pat++; end
                default: m_ready = ($urandom_range(99) < rdy_pct);
            endcase
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(int v);
        valid_in = 1'b1;
        data_in  = s16_t'(v);
        tick(1);
        valid_in = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        hs_cyc.delete();
        last_hs = 0;
    endtask

    task automatic chk_got(string name, int base, int n);
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++)
            chk(name, (i < got_q.size()) ? int'(got_q[i]) : -99999, base + i);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        valid_in = 1'b0;
        tick(3);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        clear_obs();
    endtask

    task automatic drain(int budget);
        int n = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || m_valid === 1'b1) && n < budget) begin
            tick(1);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) fail_line("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        rdy_mode = 0;
        tick(1);
        do_reset();
        tick(10);
        chk("idle_no_valid", m_valid, 0);

        // Single frame with m_ready held high
        clear_obs();
        for (int i = 1; i <= FL; i++) strobe(i);
        tick(20);
        chk("latency", t_rise - t_frame, 3);
        chk_got("single", 1, FL);
        chk("single_last_cnt", last_hs, 1);
        chk("single_burst", (hs_cyc.size() == FL) ? hs_cyc[FL-1] - hs_cyc[0] : -1, FL - 1);

        // Backpressure pattern 1,0,0,...
        clear_obs();
        rdy_mode = 2;
        for (int i = 1; i <= FL; i++) strobe(i);
        tick(40);
        chk_got("bp", 1, FL);
        chk("bp_last_cnt", last_hs, 1);

        // Overrun: both banks filled, 17th sample dropped
        clear_obs();
        rdy_mode = 1;
        tick(2);
        for (int i = 1; i <= 2 * FL + 1; i++) begin
            strobe(i);
            if (i == 2 * FL) chk("ovr_before", overrun, 0);
        end
        chk("ovr_set", overrun, 1);
        rdy_mode = 0;
        tick(40);
        chk_got("ovr", 1, 2 * FL);
        chk("ovr_sticky", overrun, 1);
        do_reset();

        // Ping-pong continuity, a strobe every 4th cycle
        for (int i = 0; i < 5 * FL; i++) begin
            strobe(1000 + i);
            tick(3);
        end
        tick(20);
        chk_got("pingpong", 1000, 5 * FL);
        chk("pingpong_ovr", overrun, 0);

        // Reset after a partial frame
        for (int i = 0; i < 5; i++) strobe(200 + i);
        do_reset();
        for (int i = 0; i < FL; i++) strobe(100 + i);
        tick(20);
        chk_got("rst_partial", 100, FL);

        // Reset in the middle of streaming a frame
        rdy_mode = 1;
        for (int i = 0; i < FL; i++) strobe(50 + i);
        tick(5);
        rdy_mode = 0;
        tick(3);
        do_reset();
        for (int i = 0; i < FL; i++) strobe(100 + i);
        tick(20);
        chk_got("rst_stream", 100, FL);

        // Randomised traffic: moderate then heavy backpressure
        rdy_mode = 3;
        for (int ph = 0; ph < 2; ph++) begin
            rdy_pct = (ph == 0) ? 60 : 12;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(2) == 0) strobe(int'($urandom_range(65535)) - 32768);
                else tick(1);
            end
        end
        valid_in = 1'b0;
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual 1 required 0");
        $fatal(1, "watchdog expired");
    end

endmodule
